ysyx_23060136_wbu_writeback: RTL and testbench

//  Writeback stage: terminal pipeline stage feeding the GPR/CSR write ports of the decode stage
//  (WB_o_rd/RegWr/rf_busW, dual CSR write ports). Holds one retiring instruction in a

---
 rtl/ysyx_23060136_wbu_writeback_if.sv | 38 +++
 rtl/ysyx_23060136_wbu_writeback.sv | 129 ++++++++++++
 tb/tb_ysyx_23060136_wbu_writeback.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060136_wbu_writeback_if.sv
// MEM -> WB handshake bundle: one retiring instruction offered with valid/ready.
// The MEM stage is the master; the writeback slot is the slave.
interface ysyx_23060136_wbu_writeback_if #(
   parameter int XLEN   = 64,
   parameter int GPR_AW = 5,
   parameter int CSR_AW = 12
);
   logic              valid;
   logic              ready;
   logic [XLEN-1:0]   pc;
   logic [31:0]       inst;
   logic              commit;
   logic [GPR_AW-1:0] rd;
   logic              write_gpr;
   logic              mem_to_reg;
   logic [XLEN-1:0]   alu_res;
   logic [XLEN-1:0]   mem_rdata;
   logic [CSR_AW-1:0] csr_rd_1;
   logic [CSR_AW-1:0] csr_rd_2;
   logic              wr_csr_1;
   logic              wr_csr_2;
   logic [XLEN-1:0]   csr_data_1;
   logic [XLEN-1:0]   csr_data_2;
   logic              halt;
   logic [XLEN-1:0]   a0;

   modport master (
      output valid, pc, inst, commit, rd, write_gpr, mem_to_reg, alu_res, mem_rdata,
             csr_rd_1, csr_rd_2, wr_csr_1, wr_csr_2, csr_data_1, csr_data_2, halt, a0,
      input  ready
   );

   modport slave (
      input  valid, pc, inst, commit, rd, write_gpr, mem_to_reg, alu_res, mem_rdata,
             csr_rd_1, csr_rd_2, wr_csr_1, wr_csr_2, csr_data_1, csr_data_2, halt, a0,
      output ready
   );
endinterface

// File: rtl/ysyx_23060136_wbu_writeback.sv
// Writeback stage: one-entry retire slot driving GPR/CSR write ports, the retired
// instruction counter and the ebreak halt state machine.
module ysyx_23060136_wbu_writeback #(
   parameter int XLEN   = 64,
   parameter int GPR_AW = 5,
   parameter int CSR_AW = 12
) (
   input  logic                         clk,
   input  logic                         rst,
   ysyx_23060136_wbu_writeback_if.slave mem,
   output logic [GPR_AW-1:0]            WB_o_rd,
   output logic                         WB_o_RegWr,
   output logic [XLEN-1:0]              WB_o_rf_busW,
   output logic [CSR_AW-1:0]            WB_o_csr_rd_1,
   output logic [CSR_AW-1:0]            WB_o_csr_rd_2,
   output logic                         WB_o_CSRWr_1,
   output logic                         WB_o_CSRWr_2,
   output logic [XLEN-1:0]              WB_o_csr_busW_1,
   output logic [XLEN-1:0]              WB_o_csr_busW_2,
   output logic                         WB_o_retire,
   output logic [XLEN-1:0]              WB_o_retire_pc,
   output logic [63:0]                  WB_o_instret,
   output logic                         WB_o_halted,
   output logic [XLEN-1:0]              WB_o_halt_code
);

   typedef enum logic [1:0] {RUN, HALT_DRAIN, HALTED} state_t;

   typedef struct packed {
      logic              valid;
      logic              commit;
      logic              halt;
      logic              write_gpr;
      logic              mem_to_reg;
      logic              wr_csr_1;
      logic              wr_csr_2;
      logic [GPR_AW-1:0] rd;
      logic [CSR_AW-1:0] csr_rd_1;
      logic [CSR_AW-1:0] csr_rd_2;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   alu_res;
      logic [XLEN-1:0]   mem_rdata;
      logic [XLEN-1:0]   csr_data_1;
      logic [XLEN-1:0]   csr_data_2;
      logic [XLEN-1:0]   a0;
   } slot_t;

   state_t          state_q, state_d;
   slot_t           slot_q, slot_in;
   logic            transfer;
   logic            live;
   logic            halt_fire;
   logic [63:0]     instret_q;
   logic [XLEN-1:0] halt_code_q;

   // The instruction word travels with the bundle for tracing only.
   logic unused_inst;
   assign unused_inst = ^mem.inst;

   always_comb begin
      slot_in            = '0;
      slot_in.valid      = 1'b1;
      slot_in.commit     = mem.commit;
      slot_in.halt       = mem.halt;
      slot_in.write_gpr  = mem.write_gpr;
      slot_in.mem_to_reg = mem.mem_to_reg;
      slot_in.wr_csr_1   = mem.wr_csr_1;
      slot_in.wr_csr_2   = mem.wr_csr_2;
      slot_in.rd         = mem.rd;
      slot_in.csr_rd_1   = mem.csr_rd_1;
      slot_in.csr_rd_2   = mem.csr_rd_2;
      slot_in.pc         = mem.pc;
      slot_in.alu_res    = mem.alu_res;
      slot_in.mem_rdata  = mem.mem_rdata;
      slot_in.csr_data_1 = mem.csr_data_1;
      slot_in.csr_data_2 = mem.csr_data_2;
      slot_in.a0         = mem.a0;
   end

   // A held ebreak blocks intake so nothing younger slips in behind it.
   assign mem.ready = (state_q == RUN) && !(slot_q.valid && slot_q.halt);
   assign transfer  = mem.valid && mem.ready;
   assign live      = slot_q.valid && slot_q.commit;
   assign halt_fire = (state_q == RUN) && live && slot_q.halt;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:        if (halt_fire) state_d = HALT_DRAIN;
         HALT_DRAIN: state_d = HALTED;
         HALTED:     state_d = HALTED;
         default:    state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register samples
      // pre-edge values; blocking here would let later statements see post-edge values.
      if (!rst) begin
         state_q     <= RUN;
         // NOTE: slot payload is reset too, because the index/data outputs are read
         // straight from it and must show zero after reset.
         slot_q      <= '0;
         instret_q   <= '0;
         halt_code_q <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= transfer ? slot_in : '0;
         if (live)      instret_q   <= instret_q + 64'd1;
         if (halt_fire) halt_code_q <= slot_q.a0;
      end
   end

   assign WB_o_rd         = slot_q.rd;
   assign WB_o_RegWr      = live && slot_q.write_gpr && (slot_q.rd != '0);
   assign WB_o_rf_busW    = slot_q.mem_to_reg ? slot_q.mem_rdata : slot_q.alu_res;
   assign WB_o_csr_rd_1   = slot_q.csr_rd_1;
   assign WB_o_csr_rd_2   = slot_q.csr_rd_2;
   assign WB_o_CSRWr_1    = live && slot_q.wr_csr_1;
   assign WB_o_CSRWr_2    = live && slot_q.wr_csr_2;
   assign WB_o_csr_busW_1 = slot_q.csr_data_1;
   assign WB_o_csr_busW_2 = slot_q.csr_data_2;
   assign WB_o_retire     = live;
   assign WB_o_retire_pc  = slot_q.pc;
   assign WB_o_instret    = instret_q;
   assign WB_o_halted     = (state_q == HALTED);
   assign WB_o_halt_code  = halt_code_q;

endmodule

// File: tb/tb_ysyx_23060136_wbu_writeback.sv
// Directed bench for the writeback stage: writes, bubbles, CSR dual write, throughput,
// halt sequencing and reset recovery.
module tb_ysyx_23060136_wbu_writeback;

   localparam int XLEN = 64;

   typedef struct {
      logic [63:0] pc;
      logic        commit;
      logic [4:0]  rd;
      logic        write_gpr;
      logic        mem_to_reg;
      logic [63:0] alu_res;
      logic [63:0] mem_rdata;
      logic [11:0] csr_rd_1;
      logic [11:0] csr_rd_2;
      logic        wr_csr_1;
      logic        wr_csr_2;
      logic [63:0] csr_data_1;
      logic [63:0] csr_data_2;
      logic        halt;
      logic [63:0] a0;
   } instr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ysyx_23060136_wbu_writeback_if bus ();

   logic [4:0]  wb_rd;
   logic        wb_regwr;
   logic [63:0] wb_busw;
   logic [11:0] wb_csr_rd_1, wb_csr_rd_2;
   logic        wb_csrwr_1, wb_csrwr_2;
   logic [63:0] wb_csr_busw_1, wb_csr_busw_2;
   logic        wb_retire;
   logic [63:0] wb_retire_pc;
   logic [63:0] wb_instret;
   logic        wb_halted;
   logic [63:0] wb_halt_code;

   int n_checks = 0;
   int n_errors = 0;

   ysyx_23060136_wbu_writeback dut (
      .clk             (clk),
      .rst             (rst),
      .mem             (bus.slave),
      .WB_o_rd         (wb_rd),
      .WB_o_RegWr      (wb_regwr),
      .WB_o_rf_busW    (wb_busw),
      .WB_o_csr_rd_1   (wb_csr_rd_1),
      .WB_o_csr_rd_2   (wb_csr_rd_2),
      .WB_o_CSRWr_1    (wb_csrwr_1),
      .WB_o_CSRWr_2    (wb_csrwr_2),
      .WB_o_csr_busW_1 (wb_csr_busw_1),
      .WB_o_csr_busW_2 (wb_csr_busw_2),
      .WB_o_retire     (wb_retire),
      .WB_o_retire_pc  (wb_retire_pc),
      .WB_o_instret    (wb_instret),
      .WB_o_halted     (wb_halted),
      .WB_o_halt_code  (wb_halt_code)
   );

   function automatic instr_t blank();
      instr_t i;
      i = '{pc: 64'h0, commit: 1'b1, rd: 5'd0, write_gpr: 1'b0, mem_to_reg: 1'b0,
            alu_res: 64'h0, mem_rdata: 64'h0, csr_rd_1: 12'h0, csr_rd_2: 12'h0,
            wr_csr_1: 1'b0, wr_csr_2: 1'b0, csr_data_1: 64'h0, csr_data_2: 64'h0,
            halt: 1'b0, a0: 64'h0};
      return i;
   endfunction

   task automatic drive(input instr_t i, input logic v);
      bus.valid      = v;
      bus.pc         = i.pc;
      bus.inst       = 32'h0000_0013;
      bus.commit     = i.commit;
      bus.rd         = i.rd;
      bus.write_gpr  = i.write_gpr;
      bus.mem_to_reg = i.mem_to_reg;
      bus.alu_res    = i.alu_res;
      bus.mem_rdata  = i.mem_rdata;
      bus.csr_rd_1   = i.csr_rd_1;
      bus.csr_rd_2   = i.csr_rd_2;
      bus.wr_csr_1   = i.wr_csr_1;
      bus.wr_csr_2   = i.wr_csr_2;
      bus.csr_data_1 = i.csr_data_1;
      bus.csr_data_2 = i.csr_data_2;
      bus.halt       = i.halt;
      bus.a0         = i.a0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(blank(), 1'b0);
      rst = 1'b0;
      repeat (3) step();
      n_checks++; if (bus.ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b want 1", bus.ready); end
      n_checks++; if ({wb_regwr, wb_csrwr_1, wb_csrwr_2, wb_retire, wb_halted} !== 5'b0) begin
         n_errors++; $display("FAIL reset_enables got %b want 00000", {wb_regwr, wb_csrwr_1, wb_csrwr_2, wb_retire, wb_halted}); end
      n_checks++; if (wb_instret !== 64'd0) begin n_errors++; $display("FAIL reset_instret got %0d want 0", wb_instret); end
      n_checks++; if ({wb_rd, wb_busw, wb_retire_pc, wb_halt_code} !== '0) begin
         n_errors++; $display("FAIL reset_data got rd=%h busW=%h pc=%h code=%h want 0", wb_rd, wb_busw, wb_retire_pc, wb_halt_code); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_add();
      instr_t i = blank();
      i.pc = 64'h8000_0000; i.rd = 5'd5; i.write_gpr = 1'b1; i.alu_res = 64'h11;
      drive(i, 1'b1);
      n_checks++; if (bus.ready !== 1'b1) begin n_errors++; $display("FAIL add_ready got %b want 1", bus.ready); end
      step();
      drive(blank(), 1'b0);
      n_checks++; if (wb_regwr !== 1'b1 || wb_rd !== 5'd5 || wb_busw !== 64'h11) begin
         n_errors++; $display("FAIL add_write got we=%b rd=%0d busW=%h want 1/5/11", wb_regwr, wb_rd, wb_busw); end
      n_checks++; if (wb_retire !== 1'b1 || wb_retire_pc !== 64'h8000_0000) begin
         n_errors++; $display("FAIL add_retire got %b pc=%h want 1 pc=80000000", wb_retire, wb_retire_pc); end
      n_checks++; if (wb_instret !== 64'd0) begin n_errors++; $display("FAIL add_instret_before got %0d want 0", wb_instret); end
      step();
      n_checks++; if (wb_instret !== 64'd1 || wb_regwr !== 1'b0) begin
         n_errors++; $display("FAIL add_instret_after got %0d we=%b want 1 we=0", wb_instret, wb_regwr); end
   endtask

   task automatic test_load();
      instr_t i = blank();
      i.pc = 64'h8000_0004; i.rd = 5'd7; i.write_gpr = 1'b1; i.mem_to_reg = 1'b1;
      i.alu_res = 64'h8000_0000; i.mem_rdata = 64'hFFFF_FFFF_FFFF_FF80;
      drive(i, 1'b1);
      step();
      drive(blank(), 1'b0);
      n_checks++; if (wb_regwr !== 1'b1 || wb_rd !== 5'd7 || wb_busw !== 64'hFFFF_FFFF_FFFF_FF80) begin
         n_errors++; $display("FAIL load_write got we=%b rd=%0d busW=%h want 1/7/ffffffffffffff80", wb_regwr, wb_rd, wb_busw); end
      step();
   endtask

   task automatic test_rd_zero();
      instr_t i = blank();
      i.pc = 64'h8000_0008; i.rd = 5'd0; i.write_gpr = 1'b1; i.alu_res = 64'hDEAD;
      drive(i, 1'b1);
      step();
      drive(blank(), 1'b0);
      n_checks++; if (wb_regwr !== 1'b0 || wb_retire !== 1'b1) begin
         n_errors++; $display("FAIL rd0 got we=%b retire=%b want we=0 retire=1", wb_regwr, wb_retire); end
      step();
      n_checks++; if (wb_instret !== 64'd3) begin n_errors++; $display("FAIL rd0_instret got %0d want 3", wb_instret); end
   endtask

   task automatic test_ecall();
      instr_t i = blank();
      i.pc = 64'h8000_0010; i.wr_csr_1 = 1'b1; i.wr_csr_2 = 1'b1;
      i.csr_rd_1 = 12'h341; i.csr_rd_2 = 12'h342;
      i.csr_data_1 = 64'h8000_0010; i.csr_data_2 = 64'd11;
      drive(i, 1'b1);
      step();
      drive(blank(), 1'b0);
      n_checks++; if (wb_csrwr_1 !== 1'b1 || wb_csrwr_2 !== 1'b1 || wb_regwr !== 1'b0) begin
         n_errors++; $display("FAIL ecall_we got csr1=%b csr2=%b gpr=%b want 1/1/0", wb_csrwr_1, wb_csrwr_2, wb_regwr); end
      n_checks++; if (wb_csr_rd_1 !== 12'h341 || wb_csr_rd_2 !== 12'h342) begin
         n_errors++; $display("FAIL ecall_idx got %h/%h want 341/342", wb_csr_rd_1, wb_csr_rd_2); end
      n_checks++; if (wb_csr_busw_1 !== 64'h8000_0010 || wb_csr_busw_2 !== 64'd11) begin
         n_errors++; $display("FAIL ecall_data got %h/%h want 80000010/b", wb_csr_busw_1, wb_csr_busw_2); end
      step();
      n_checks++; if (wb_csrwr_1 !== 1'b0 || wb_csrwr_2 !== 1'b0 || wb_instret !== 64'd4) begin
         n_errors++; $display("FAIL ecall_after got csr1=%b csr2=%b instret=%0d want 0/0/4", wb_csrwr_1, wb_csrwr_2, wb_instret); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 12; k++) begin
         instr_t i = blank();
         logic bubble;
         bubble = (k == 3) || (k == 8);
         i.pc = 64'h8000_1000 + 64'(4 * k);
         i.commit = !bubble; i.rd = 5'(k + 1); i.write_gpr = 1'b1;
         i.alu_res = 64'h100 + 64'(k); i.wr_csr_1 = bubble;
         drive(i, 1'b1);
         n_checks++; if (bus.ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready[%0d] got %b want 1", k, bus.ready); end
         step();
         n_checks++; if (wb_regwr !== !bubble || wb_retire !== !bubble || wb_csrwr_1 !== 1'b0) begin
            n_errors++; $display("FAIL b2b_we[%0d] got we=%b retire=%b csr1=%b want %b/%b/0", k, wb_regwr, wb_retire, wb_csrwr_1, !bubble, !bubble); end
         n_checks++; if (wb_busw !== 64'h100 + 64'(k) || wb_rd !== 5'(k + 1)) begin
            n_errors++; $display("FAIL b2b_data[%0d] got busW=%h rd=%0d want %h/%0d", k, wb_busw, wb_rd, 64'h100 + 64'(k), k + 1); end
      end
      drive(blank(), 1'b0);
      step();
      n_checks++; if (wb_instret !== 64'd14) begin n_errors++; $display("FAIL b2b_instret got %0d want 14", wb_instret); end
   endtask

   task automatic test_bubble_halt();
      instr_t i = blank();
      i.commit = 1'b0; i.halt = 1'b1; i.a0 = 64'h77;
      drive(i, 1'b1);
      step();
      drive(blank(), 1'b0);
      n_checks++; if (wb_retire !== 1'b0 || bus.ready !== 1'b0) begin
         n_errors++; $display("FAIL bhalt_slot got retire=%b ready=%b want 0/0", wb_retire, bus.ready); end
      step();
      n_checks++; if (bus.ready !== 1'b1 || wb_halted !== 1'b0) begin
         n_errors++; $display("FAIL bhalt_run got ready=%b halted=%b want 1/0", bus.ready, wb_halted); end
      i = blank(); i.rd = 5'd3; i.write_gpr = 1'b1; i.alu_res = 64'h33;
      drive(i, 1'b1);
      step();
      drive(blank(), 1'b0);
      n_checks++; if (wb_regwr !== 1'b1 || wb_busw !== 64'h33) begin
         n_errors++; $display("FAIL bhalt_next got we=%b busW=%h want 1/33", wb_regwr, wb_busw); end
      step();
      n_checks++; if (wb_instret !== 64'd15 || wb_halt_code !== 64'd0) begin
         n_errors++; $display("FAIL bhalt_count got instret=%0d code=%h want 15/0", wb_instret, wb_halt_code); end
   endtask

   task automatic test_ebreak();
      instr_t e = blank();
      instr_t a = blank();
      e.pc = 64'h8000_0100; e.halt = 1'b1; e.a0 = 64'd0;
      a.pc = 64'h8000_0104; a.rd = 5'd9; a.write_gpr = 1'b1; a.alu_res = 64'h55;
      drive(e, 1'b1);
      step();
      drive(a, 1'b1);
      n_checks++; if (bus.ready !== 1'b0 || wb_retire !== 1'b1 || wb_halted !== 1'b0) begin
         n_errors++; $display("FAIL ebreak_slot got ready=%b retire=%b halted=%b want 0/1/0", bus.ready, wb_retire, wb_halted); end
      step();
      n_checks++; if (bus.ready !== 1'b0 || wb_halted !== 1'b0 || wb_regwr !== 1'b0 || wb_retire !== 1'b0) begin
         n_errors++; $display("FAIL ebreak_drain got ready=%b halted=%b we=%b retire=%b want 0/0/0/0", bus.ready, wb_halted, wb_regwr, wb_retire); end
      step();
      n_checks++; if (wb_halted !== 1'b1 || wb_halt_code !== 64'd0 || wb_instret !== 64'd16) begin
         n_errors++; $display("FAIL ebreak_halted got halted=%b code=%h instret=%0d want 1/0/16", wb_halted, wb_halt_code, wb_instret); end
      repeat (3) step();
      n_checks++; if (wb_halted !== 1'b1 || bus.ready !== 1'b0 || wb_regwr !== 1'b0 || wb_retire !== 1'b0 || wb_instret !== 64'd16) begin
         n_errors++; $display("FAIL ebreak_absorb got halted=%b ready=%b we=%b retire=%b instret=%0d want 1/0/0/0/16",
                              wb_halted, bus.ready, wb_regwr, wb_retire, wb_instret); end
      rst = 1'b0;
      step();
      n_checks++; if (wb_halted !== 1'b0 || bus.ready !== 1'b1 || wb_instret !== 64'd0 || wb_regwr !== 1'b0 || wb_busw !== 64'd0) begin
         n_errors++; $display("FAIL ebreak_reset got halted=%b ready=%b instret=%0d we=%b busW=%h want 0/1/0/0/0",
                              wb_halted, bus.ready, wb_instret, wb_regwr, wb_busw); end
      drive(blank(), 1'b0);
      rst = 1'b1;
      step();
   endtask

   task automatic test_halt_code();
      instr_t e = blank();
      e.pc = 64'h8000_0200; e.halt = 1'b1; e.a0 = 64'h2A;
      drive(e, 1'b1);
      step();
      drive(blank(), 1'b0);
      step();
      step();
      n_checks++; if (wb_halted !== 1'b1 || wb_halt_code !== 64'h2A || wb_instret !== 64'd1) begin
         n_errors++; $display("FAIL halt_code got halted=%b code=%h instret=%0d want 1/2a/1", wb_halted, wb_halt_code, wb_instret); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_load();
      test_rd_zero();
      test_ecall();
      test_back_to_back();
      test_bubble_halt();
      test_ebreak();
      test_halt_code();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
